// File: rtl/retire_stage.sv
// retire_stage: commits up to three reorder-buffer entries per cycle, maintains the committed map and frees Told tags.
// Optional RETIRE_STATS_EN adds saturating inst_count / recover_count statistics outputs.
`ifndef PR
`define PR 6
`endif
`ifndef XLEN
`define XLEN 32
`endif

package retire_pkg;
    typedef struct packed {
        logic              valid;
        logic              completed;
        logic [`PR-1:0]    Tnew;
        logic [`PR-1:0]    Told;
        logic [4:0]        arch_reg;
        logic              precise_state_need;
        logic [`XLEN-1:0]  target_pc;
        logic              halt;
    } ROB_ENTRY_PACKET;
endpackage

module retire_stage
    import retire_pkg::*;
(
    input  logic                      clock,
    input  logic                      reset,
    input  ROB_ENTRY_PACKET [2:0]     retire_entry,
    output logic [31:0][`PR-1:0]      arch_maptable,
    output logic [2:0][`PR-1:0]       free_preg,
    output logic [2:0]                free_valid,
    output logic [1:0]                retire_num,
    output logic                      BPRecoverEN,
    output logic [`XLEN-1:0]          recover_pc,
    output logic                      halt
`ifdef RETIRE_STATS_EN
    ,
    output logic [63:0]               inst_count,
    output logic [31:0]               recover_count
`endif
);
    typedef enum logic [1:0] {RUN, RECOVER, HALTED} state_t;
    state_t state, state_n;
    logic go;
    logic [2:0] commit;
    logic [31:0][`PR-1:0] map_n;
    logic [2:0][`PR-1:0] free_preg_n;
    logic [2:0] free_valid_n;
    logic [1:0] retire_num_n;
    logic recover_n, halt_n;
    logic [`XLEN-1:0] recover_pc_n;

    always_comb begin
        go = (state == RUN);
        commit = '0;
        map_n = arch_maptable;
        free_preg_n = '0;
        free_valid_n = '0;
        retire_num_n = '0;
        recover_n = 1'b0;
        halt_n = halt;
        recover_pc_n = recover_pc;
        state_n = (state == RECOVER) ? RUN : state;
        // Oldest first; slot 0 is visited last so the youngest write to a shared arch_reg wins.
        for (int i = 2; i >= 0; i--) begin
            commit[i] = go & retire_entry[i].valid & retire_entry[i].completed;
            go = commit[i] & ~retire_entry[i].precise_state_need & ~retire_entry[i].halt;
            if (commit[i]) begin
                retire_num_n = retire_num_n + 2'd1;
                if (retire_entry[i].arch_reg != 5'd0) begin
                    map_n[retire_entry[i].arch_reg] = retire_entry[i].Tnew;
                    free_preg_n[i] = retire_entry[i].Told;
                    free_valid_n[i] = 1'b1;
                end
                if (retire_entry[i].halt) begin
                    halt_n = 1'b1;
                    state_n = HALTED;
                end else if (retire_entry[i].precise_state_need) begin
                    recover_n = 1'b1;
                    recover_pc_n = retire_entry[i].target_pc;
                    state_n = RECOVER;
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= RUN;
            for (int i = 0; i < 32; i++) arch_maptable[i] <= `PR'(i);
            free_preg <= '0;
            free_valid <= '0;
            retire_num <= '0;
            BPRecoverEN <= 1'b0;
            recover_pc <= '0;
            halt <= 1'b0;
        end else begin
            state <= state_n;
            arch_maptable <= map_n;
            free_preg <= free_preg_n;
            free_valid <= free_valid_n;
            retire_num <= retire_num_n;
            BPRecoverEN <= recover_n;
            recover_pc <= recover_pc_n;
            halt <= halt_n;
        end
    end

`ifdef RETIRE_STATS_EN
    logic [64:0] inst_sum;
    assign inst_sum = {1'b0, inst_count} + {63'd0, retire_num};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            inst_count <= '0;
            recover_count <= '0;
        end else begin
            inst_count <= inst_sum[64] ? '1 : inst_sum[63:0];
            recover_count <= recover_count + {31'd0, BPRecoverEN & ~&recover_count};
        end
    end
`endif
endmodule

// File: tb/tb_retire_stage.sv
// tb_retire_stage: directed-vector bench for retire_stage; stats checks compile in with RETIRE_STATS_EN.
`ifndef PR
`define PR 6
`endif
`ifndef XLEN
`define XLEN 32
`endif

module tb_retire_stage;
    import retire_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b1;
    ROB_ENTRY_PACKET [2:0] retire_entry = '0;
    logic [31:0][`PR-1:0] arch_maptable;
    logic [2:0][`PR-1:0] free_preg;
    logic [2:0] free_valid;
    logic [1:0] retire_num;
    logic BPRecoverEN;
    logic [`XLEN-1:0] recover_pc;
    logic halt;
`ifdef RETIRE_STATS_EN
    logic [63:0] inst_count;
    logic [31:0] recover_count;
`endif
    int checks = 0;
    int errors = 0;

    retire_stage dut (
        .clock(clock),
        .reset(reset),
        .retire_entry(retire_entry),
        .arch_maptable(arch_maptable),
        .free_preg(free_preg),
        .free_valid(free_valid),
        .retire_num(retire_num),
        .BPRecoverEN(BPRecoverEN),
        .recover_pc(recover_pc),
        .halt(halt)
`ifdef RETIRE_STATS_EN
        ,
        .inst_count(inst_count),
        .recover_count(recover_count)
`endif
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    function automatic ROB_ENTRY_PACKET ent(input logic v, input logic c, input int tn, input int to,
                                             input int ar, input logic p, input int pc, input logic h);
        ROB_ENTRY_PACKET e;
        e.valid = v;
        e.completed = c;
        e.Tnew = `PR'(tn);
        e.Told = `PR'(to);
        e.arch_reg = 5'(ar);
        e.precise_state_need = p;
        e.target_pc = `XLEN'(pc);
        e.halt = h;
        return e;
    endfunction

    initial begin
        step();
        step();
        check("rst_map0", arch_maptable[0], 0);
        check("rst_map31", arch_maptable[31], 31);
        check("rst_fv", free_valid, 0);
        check("rst_fp", free_preg, 0);
        check("rst_num", retire_num, 0);
        check("rst_rec", BPRecoverEN, 0);
        check("rst_pc", recover_pc, 0);
        check("rst_halt", halt, 0);
        reset = 1'b0;

        retire_entry[2] = ent(1, 1, 40, 5, 5, 0, 0, 0);
        retire_entry[1] = ent(1, 1, 41, 6, 6, 0, 0, 0);
        retire_entry[0] = ent(1, 1, 42, 7, 7, 0, 0, 0);
        step();
        check("s1_map5", arch_maptable[5], 40);
        check("s1_map6", arch_maptable[6], 41);
        check("s1_map7", arch_maptable[7], 42);
        check("s1_fv", free_valid, 3'b111);
        check("s1_fp", free_preg, {6'd5, 6'd6, 6'd7});
        check("s1_num", retire_num, 3);
        check("s1_rec", BPRecoverEN, 0);

        retire_entry = '0;
        step();
        check("idle_num", retire_num, 0);
        check("idle_fv", free_valid, 0);
        check("idle_map5", arch_maptable[5], 40);

        retire_entry[2] = ent(1, 1, 43, 8, 8, 0, 0, 0);
        retire_entry[1] = ent(1, 0, 44, 9, 9, 0, 0, 0);
        retire_entry[0] = ent(1, 1, 45, 10, 10, 0, 0, 0);
        step();
        check("s2_num", retire_num, 1);
        check("s2_map8", arch_maptable[8], 43);
        check("s2_map9", arch_maptable[9], 9);
        check("s2_map10", arch_maptable[10], 10);
        check("s2_fv", free_valid, 3'b100);

        retire_entry[2] = ent(1, 1, 46, 11, 11, 0, 0, 0);
        retire_entry[1] = ent(1, 1, 47, 12, 12, 1, 32'h1000, 0);
        retire_entry[0] = ent(1, 1, 48, 13, 13, 0, 0, 0);
        step();
        check("s3_num", retire_num, 2);
        check("s3_rec", BPRecoverEN, 1);
        check("s3_pc", recover_pc, 32'h1000);
        check("s3_map12", arch_maptable[12], 47);
        check("s3_map13", arch_maptable[13], 13);
        check("s3_fv", free_valid, 3'b110);
        retire_entry = '0;
        retire_entry[2] = ent(1, 1, 49, 14, 14, 0, 0, 0);
        step();
        check("s3_ign_rec", BPRecoverEN, 0);
        check("s3_ign_num", retire_num, 0);
        check("s3_ign_fv", free_valid, 0);
        check("s3_ign_map14", arch_maptable[14], 14);
        check("s3_hold_pc", recover_pc, 32'h1000);
        step();
        check("s3_run_num", retire_num, 1);
        check("s3_run_map14", arch_maptable[14], 49);
        check("s3_run_pc", recover_pc, 32'h1000);

        retire_entry[2] = ent(1, 1, 50, 3, 3, 0, 0, 0);
        retire_entry[1] = ent(1, 1, 51, 4, 4, 0, 0, 0);
        retire_entry[0] = ent(1, 1, 52, 50, 3, 0, 0, 0);
        step();
        check("s4_map3", arch_maptable[3], 52);
        check("s4_map4", arch_maptable[4], 51);
        check("s4_fp", free_preg, {6'd3, 6'd4, 6'd50});
        check("s4_fv", free_valid, 3'b111);

        retire_entry = '0;
        retire_entry[2] = ent(1, 1, 55, 56, 0, 0, 0, 0);
        step();
        check("r0_num", retire_num, 1);
        check("r0_fv", free_valid, 0);
        check("r0_map0", arch_maptable[0], 0);

        retire_entry[2] = ent(0, 1, 57, 15, 15, 0, 0, 0);
        retire_entry[1] = ent(1, 1, 58, 16, 16, 0, 0, 0);
        retire_entry[0] = ent(1, 1, 59, 17, 17, 0, 0, 0);
        step();
        check("ne2_num", retire_num, 0);
        check("ne2_map16", arch_maptable[16], 16);

        retire_entry = '0;
        retire_entry[2] = ent(1, 1, 60, 1, 1, 1, 32'h3000, 0);
        step();
        check("rr_rec", BPRecoverEN, 1);
        #2 reset = 1'b1;
        #1;
        check("rr_async_rec", BPRecoverEN, 0);
        check("rr_async_map1", arch_maptable[1], 1);
        check("rr_async_pc", recover_pc, 0);
        reset = 1'b0;
        retire_entry = '0;
        step();
        check("rr_post_rec", BPRecoverEN, 0);
        check("rr_post_num", retire_num, 0);

        retire_entry[2] = ent(1, 1, 53, 20, 20, 1, 32'h2000, 1);
        retire_entry[1] = ent(1, 1, 61, 21, 21, 0, 0, 0);
        step();
        check("h_halt", halt, 1);
        check("h_num", retire_num, 1);
        check("h_map20", arch_maptable[20], 53);
        check("h_map21", arch_maptable[21], 21);
        check("h_rec", BPRecoverEN, 0);
        check("h_pc", recover_pc, 0);
        retire_entry = '0;
        retire_entry[2] = ent(1, 1, 54, 22, 22, 0, 0, 0);
        step();
        step();
        check("hd_num", retire_num, 0);
        check("hd_map22", arch_maptable[22], 22);
        check("hd_halt", halt, 1);
        check("hd_fv", free_valid, 0);
        check("hd_rec", BPRecoverEN, 0);
        #2 reset = 1'b1;
        #1;
        check("hr_map20", arch_maptable[20], 20);
        check("hr_halt", halt, 0);
        reset = 1'b0;
        retire_entry = '0;
        step();
        check("hr_post_halt", halt, 0);
        check("hr_post_rec", BPRecoverEN, 0);

`ifdef RETIRE_STATS_EN
        reset = 1'b1;
        #1;
        check("st_rst_inst", inst_count, 0);
        check("st_rst_rec", recover_count, 0);
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            retire_entry[2] = ent(1, 1, 30, 1, 1, 0, 0, 0);
            retire_entry[1] = ent(1, 1, 31, 2, 2, 0, 0, 0);
            retire_entry[0] = ent(1, 1, 32, 3, 3, k == 3, 32'h4000, 0);
            step();
        end
        retire_entry = '0;
        step();
        check("st_inst", inst_count, 12);
        check("st_rec", recover_count, 1);
        step();
        check("st_inst_hold", inst_count, 12);
        check("st_rec_hold", recover_count, 1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
